// File: rtl/trap_pkg.sv
// trap_pkg: cause codes, mtvec modes, FSM states and MIE index shared by the trap sequencer.
package trap_pkg;
  localparam logic [4:0] CAUSE_INST_MIS  = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK    = 5'd3;
  localparam logic [4:0] CAUSE_LOAD_MIS  = 5'd4;
  localparam logic [4:0] CAUSE_STORE_MIS = 5'd6;
  localparam logic [4:0] CAUSE_ECALL     = 5'd11;
  localparam logic [4:0] IRQ_CODE        = 5'd11;
  localparam logic [31:0] CAUSE_IRQ      = 32'h8000_000B;
  localparam logic [1:0] MTVEC_DIRECT    = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED  = 2'b01;
  localparam int MIE_BIT = 3;
  typedef enum logic [1:0] {IDLE, PEND, REDIR} state_e;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: multi-flop synchronizer for the asynchronous external interrupt level.
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= '0;
    else r_sync <= {r_sync[STAGES-2:0], i_async};
  assign o_sync = r_sync[STAGES-1];
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-side trap/MRET sequencer producing CSR update pulses, pipeline flush and PC redirect.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [31:0]     commit_inst,
  input  logic [XLEN-1:0] commit_addr,
  input  logic            exc_inst_mis,
  input  logic            exc_illegal,
  input  logic            exc_ebreak,
  input  logic            exc_ecall,
  input  logic            exc_load_mis,
  input  logic            exc_store_mis,
  input  logic            is_mret_in,
  input  logic            ext_irq,
  input  logic            csr_w,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc_i,
  output logic            is_trap,
  output logic            is_mret,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);
  state_e          r_state;
  logic            r_mret, r_irq, r_flush, r_redir_valid, r_commit_ready;
  logic [XLEN-1:0] r_mepc, r_mcause, r_mtval;
  logic            w_irq_s, w_exc, w_irq, w_take, w_fire, w_unused;
  logic [4:0]      w_code;
  logic [XLEN-1:0] w_cause, w_tval, w_base;

  irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(ext_irq),
    .o_sync (w_irq_s)
  );

  assign w_exc  = exc_inst_mis | exc_illegal | exc_ebreak | exc_ecall | exc_load_mis | exc_store_mis;
  assign w_irq  = w_irq_s & mstatus[MIE_BIT] & ~w_exc & ~is_mret_in;
  assign w_take = (r_state == IDLE) & commit_valid & (w_exc | is_mret_in | w_irq);
  assign w_code = exc_inst_mis ? CAUSE_INST_MIS : exc_illegal ? CAUSE_ILLEGAL :
                  exc_ebreak ? CAUSE_EBREAK : exc_ecall ? CAUSE_ECALL :
                  exc_load_mis ? CAUSE_LOAD_MIS : CAUSE_STORE_MIS;
  assign w_cause = w_exc ? XLEN'(w_code) : {1'b1, (XLEN-1)'(IRQ_CODE)};
  assign w_tval  = exc_inst_mis ? commit_addr : exc_illegal ? XLEN'(commit_inst) :
                   exc_ebreak ? commit_pc : exc_ecall ? '0 :
                   (exc_load_mis | exc_store_mis) ? commit_addr : '0;
  assign w_base  = {mtvec[XLEN-1:2], 2'b00};
  assign w_unused = &{1'b0, mstatus[XLEN-1:MIE_BIT+1], mstatus[MIE_BIT-1:0]};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state        <= IDLE;
      r_mret         <= 1'b0;
      r_irq          <= 1'b0;
      r_flush        <= 1'b0;
      r_redir_valid  <= 1'b0;
      r_commit_ready <= 1'b1;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_take) begin
          r_state        <= PEND;
          r_flush        <= 1'b1;
          r_commit_ready <= 1'b0;
          r_mret         <= ~w_exc & is_mret_in;
          r_irq          <= w_irq;
          // MRET leaves the shadow cause/tval alone so the CSR rewrite is a no-op
          if (w_exc | w_irq) begin
            r_mepc   <= commit_pc;
            r_mcause <= w_cause;
            r_mtval  <= w_tval;
          end
        end
        PEND: if (!csr_w) begin
          r_state       <= REDIR;
          r_redir_valid <= 1'b1;
        end
        REDIR: if (redirect_ready) begin
          r_state        <= IDLE;
          r_flush        <= 1'b0;
          r_redir_valid  <= 1'b0;
          r_commit_ready <= 1'b1;
          r_mret         <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end

  assign w_fire         = (r_state == PEND) & ~csr_w;
  assign is_trap        = w_fire & ~r_mret;
  assign is_mret        = w_fire & r_mret;
  assign mepc           = r_mret ? mepc_i : r_mepc;
  assign mcause         = r_mcause;
  assign mtval          = r_mtval;
  assign flush          = r_flush;
  assign redirect_valid = r_redir_valid;
  assign commit_ready   = r_commit_ready;
  assign redirect_pc    = (r_state != REDIR) ? '0 : r_mret ? mepc_i :
                          (mtvec[1:0] == MTVEC_VECTORED && r_irq) ? w_base + (XLEN'(r_mcause[4:0]) << 2) : w_base;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed stimulus with a scoreboard queue; a negedge monitor checks every pulse and redirect.
module tb_trap_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        commit_valid = 0, commit_ready;
  logic [31:0] commit_pc = 0, commit_inst = 0, commit_addr = 0;
  logic        exc_inst_mis = 0, exc_illegal = 0, exc_ebreak = 0, exc_ecall = 0, exc_load_mis = 0, exc_store_mis = 0;
  logic        is_mret_in = 0, ext_irq = 0, csr_w = 0;
  logic [31:0] mstatus = 0, mtvec = 0, mepc_i = 0;
  logic        is_trap, is_mret, flush, redirect_valid, redirect_ready = 1;
  logic [31:0] mepc, mcause, mtval, redirect_pc;

  typedef struct {
    logic        mret;
    logic [31:0] mepc, mcause, mtval, rpc;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  bit   cur_v = 0;
  int   n_chk = 0, n_pass = 0;

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_addr(commit_addr),
    .exc_inst_mis(exc_inst_mis), .exc_illegal(exc_illegal), .exc_ebreak(exc_ebreak),
    .exc_ecall(exc_ecall), .exc_load_mis(exc_load_mis), .exc_store_mis(exc_store_mis),
    .is_mret_in(is_mret_in), .ext_irq(ext_irq), .csr_w(csr_w), .mstatus(mstatus),
    .mtvec(mtvec), .mepc_i(mepc_i), .is_trap(is_trap), .is_mret(is_mret), .mepc(mepc),
    .mcause(mcause), .mtval(mtval), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic push(input logic m, input logic [31:0] pc, cause, tval, rpc);
    exp_t e;
    e.mret = m; e.mepc = pc; e.mcause = cause; e.mtval = tval; e.rpc = rpc;
    q.push_back(e);
  endtask

  // exc bits: {inst_mis, illegal, ebreak, ecall, load_mis, store_mis}
  task automatic commit(input logic [31:0] pc, inst, addr, input logic [5:0] exc, input logic m);
    commit_pc = pc; commit_inst = inst; commit_addr = addr; is_mret_in = m; commit_valid = 1;
    {exc_inst_mis, exc_illegal, exc_ebreak, exc_ecall, exc_load_mis, exc_store_mis} = exc;
    @(posedge clk); #1;
    commit_valid = 0; is_mret_in = 0;
    {exc_inst_mis, exc_illegal, exc_ebreak, exc_ecall, exc_load_mis, exc_store_mis} = '0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!commit_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, commit_ready, 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) cur_v = 0;
    else begin
      if (is_trap || is_mret) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pulse: got trap=%0b mret=%0b expected none", is_trap, is_mret);
        end else begin
          cur = q.pop_front();
          cur_v = 1;
          check("pulse_trap", is_trap, !cur.mret);
          check("pulse_mret", is_mret, cur.mret);
          check("mepc", mepc, cur.mepc);
          check("mcause", mcause, cur.mcause);
          check("mtval", mtval, cur.mtval);
        end
      end
      if (redirect_valid) begin
        if (!cur_v) begin
          n_chk++;
          $display("FAIL unexpected_redirect: got pc=%h expected no redirect", redirect_pc);
        end else begin
          check("redirect_pc", redirect_pc, cur.rpc);
          check("redirect_flush", flush, 1);
          if (redirect_ready) cur_v = 0;
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_ready", commit_ready, 1);
    check("rst_flush", flush, 0);
    check("rst_rv", redirect_valid, 0);
    check("rst_mcause", mcause, 0);
    check("rst_mtval", mtval, 0);
    check("rst_rpc", redirect_pc, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    mtvec = 32'h200;
    push(0, 32'h100, 11, 0, 32'h200);
    commit(32'h100, 32'h0000_0073, 0, 6'b000100, 0); wait_idle("ecall_done");
    push(0, 32'h40, 2, 32'hFFFF_FFFF, 32'h200);
    commit(32'h40, 32'hFFFF_FFFF, 32'h1234, 6'b010010, 0); wait_idle("illegal_done");
    mepc_i = 32'h104;
    push(1, 32'h104, 2, 32'hFFFF_FFFF, 32'h104);
    commit(32'h44, 32'h3020_0073, 0, 6'b000000, 1); wait_idle("mret_done");
    push(0, 32'h60, 0, 32'h63, 32'h200);
    commit(32'h60, 32'hFFFF_FFFF, 32'h63, 6'b110000, 0); wait_idle("instmis_done");
    push(0, 32'h50, 3, 32'h50, 32'h200);
    commit(32'h50, 32'h0010_0073, 32'h999, 6'b001000, 1); wait_idle("ebreak_mret_done");
    push(0, 32'h70, 4, 32'h88, 32'h200);
    commit(32'h70, 32'h13, 32'h88, 6'b000011, 0); wait_idle("loadmis_done");
    push(0, 32'h74, 6, 32'h8A, 32'h200);
    commit(32'h74, 32'h13, 32'h8A, 6'b000001, 0); wait_idle("storemis_done");
    mtvec = 32'h301; mstatus = 32'h8; ext_irq = 1;
    repeat (3) @(posedge clk);
    #1;
    push(0, 32'h80, 32'h8000_000B, 0, 32'h32C);
    commit(32'h80, 32'h13, 0, 6'b000000, 0); wait_idle("irq_done");
    mepc_i = 32'h84;
    push(1, 32'h84, 32'h8000_000B, 0, 32'h84);
    commit(32'h84, 32'h3020_0073, 0, 6'b000000, 1); wait_idle("mret_over_irq_done");
    push(0, 32'h88, 11, 0, 32'h300);
    commit(32'h88, 32'h73, 0, 6'b000100, 0); wait_idle("vec_ecall_done");
    mstatus = 0;
    commit(32'h90, 32'h13, 0, 6'b000000, 0);
    check("mie0_no_trap", commit_ready, 1);
    ext_irq = 0; mtvec = 32'h200;
    repeat (3) @(posedge clk);
    #1;
    csr_w = 1; redirect_ready = 0;
    push(0, 32'h100, 11, 0, 32'h200);
    commit(32'h100, 32'h73, 0, 6'b000100, 0);
    for (int i = 0; i < 3; i++) begin
      check("stall_no_pulse", is_trap, 0);
      check("stall_flush", flush, 1);
      @(posedge clk); #1;
    end
    csr_w = 0;
    @(posedge clk); #1;
    check("redir_valid", redirect_valid, 1);
    @(posedge clk); #1;
    check("redir_held", redirect_valid, 1);
    @(posedge clk); #1;
    redirect_ready = 1;
    wait_idle("stall_done");
    redirect_ready = 0;
    push(0, 32'h200, 3, 32'h200, 32'h200);
    commit(32'h200, 32'h0010_0073, 0, 6'b001000, 0);
    @(posedge clk); #1;
    check("redir_before_rst", redirect_valid, 1);
    rst_n = 0; #1;
    check("arst_rv", redirect_valid, 0);
    check("arst_flush", flush, 0);
    check("arst_ready", commit_ready, 1);
    check("arst_rpc", redirect_pc, 0);
    check("arst_mcause", mcause, 0);
    check("arst_mtval", mtval, 0);
    check("arst_mepc", mepc, 0);
    @(posedge clk); #1;
    rst_n = 1; redirect_ready = 1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_ready", commit_ready, 1);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
